// File: rtl/extbus_mport_regfile.sv
// Multi-port register file for the 72-bit external bus: registered reads, lowest-index-wins
// write arbitration, collision flags and counter. Define EXTBUS_WR_BYPASS_EN for write-to-read forwarding.

module extbus_mport_lane #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] rword,
  output logic [W-1:0] rdata
);
  // A writing port echoes its own data; a disabled port holds its last value.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (en) rdata <= we ? wdata : rword;
  end
endmodule

module extbus_mport_regfile #(
  parameter int W      = 72,
  parameter int DEPTH  = 4,
  parameter int NPORTS = 4,
  parameter int CW     = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    port_en,
  input  logic [NPORTS-1:0]    port_we,
  input  logic [NPORTS*AW-1:0] port_addr,
  input  logic [NPORTS*W-1:0]  port_wdata,
  output logic [NPORTS*W-1:0]  port_rdata,
  output logic [NPORTS-1:0]    wr_conflict,
  output logic [CW-1:0]        conflict_cnt
);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  logic [NPORTS-1:0][AW-1:0] addr;
  logic [NPORTS-1:0][W-1:0]  wdata;
  logic [NPORTS-1:0][W-1:0]  rword;
  logic [NPORTS-1:0]         in_range, wr_req, lose, wr_win;

  always_comb begin
    lose = '0;
    for (int i = 0; i < NPORTS; i++) begin
      addr[i]     = port_addr[i*AW +: AW];
      wdata[i]    = port_wdata[i*W +: W];
      in_range[i] = ({1'b0, addr[i]} < DEPTH_L);
      wr_req[i]   = port_en[i] & port_we[i] & in_range[i];
    end
    // Any lower-index writer to the same word takes priority.
    for (int i = 1; i < NPORTS; i++)
      for (int j = 0; j < i; j++)
        if (wr_req[i] && wr_req[j] && addr[i] == addr[j]) lose[i] = 1'b1;
    wr_win = wr_req & ~lose;
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rword[i] = '0;
      if (in_range[i]) rword[i] = mem[addr[i]];
`ifdef EXTBUS_WR_BYPASS_EN
      for (int j = 0; j < NPORTS; j++)
        if (wr_win[j] && addr[j] == addr[i]) rword[i] = wdata[j];
`endif
    end
  end

  // Winners address distinct words, so the loop order never matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++)
        if (wr_win[i]) mem[addr[i]] <= wdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_conflict  <= '0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= lose;
      if (|lose && conflict_cnt != {CW{1'b1}}) conflict_cnt <= conflict_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_lane
    extbus_mport_lane #(.W(W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (port_en[i]),
      .we    (port_we[i]),
      .wdata (wdata[i]),
      .rword (rword[i]),
      .rdata (port_rdata[i*W +: W])
    );
  end
endmodule

// File: tb/tb_extbus_mport_regfile.sv
// Scoreboard bench for extbus_mport_regfile: directed cases then random traffic against an array model.
// A second instance with CW=2 shares the stimulus to exercise counter saturation.

module tb_extbus_mport_regfile;
  localparam int W = 72, DEPTH = 4, NP = 4, AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [NP-1:0]    port_en = '0, port_we = '0;
  logic [NP*AW-1:0] port_addr = '0;
  logic [NP*W-1:0]  port_wdata = '0;
  logic [NP*W-1:0]  rdata_a, rdata_b;
  logic [NP-1:0]    wc_a, wc_b;
  logic [15:0]      cnt_a;
  logic [1:0]       cnt_b;

  extbus_mport_regfile #(.W(W), .DEPTH(DEPTH), .NPORTS(NP), .CW(16)) dut (
    .clk(clk), .reset(reset), .port_en(port_en), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(rdata_a), .wr_conflict(wc_a), .conflict_cnt(cnt_a));

  extbus_mport_regfile #(.W(W), .DEPTH(DEPTH), .NPORTS(NP), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .port_en(port_en), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(rdata_b), .wr_conflict(wc_b), .conflict_cnt(cnt_b));

  typedef struct {
    logic [W-1:0]  rd [NP];
    logic [NP-1:0] wc;
    int            cnt;
    int            cnt2;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;

  // reference state
  logic [W-1:0]  mm [DEPTH];
  logic [W-1:0]  mrd [NP];
  int            mcnt = 0, mcnt2 = 0;
  // staging for the next cycle's stimulus
  int            sa [NP];
  logic [W-1:0]  sd [NP];

  task automatic cyc(input logic rst, input logic [NP-1:0] en, input logic [NP-1:0] we);
    logic [W-1:0]  old [DEPTH];
    logic [W-1:0]  win_d [DEPTH];
    bit            claimed [DEPTH];
    logic [NP-1:0] wc;
    exp_t          e;
    @(negedge clk);
    reset = rst; port_en = en; port_we = we;
    for (int i = 0; i < NP; i++) begin
      port_addr[i*AW +: AW] = AW'(sa[i]);
      port_wdata[i*W +: W]  = sd[i];
    end
    wc = '0;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mm[k] = '0;
      for (int i = 0; i < NP; i++) mrd[i] = '0;
      mcnt = 0; mcnt2 = 0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin old[k] = mm[k]; claimed[k] = 0; win_d[k] = '0; end
      for (int i = 0; i < NP; i++)
        if (en[i] && we[i]) begin
          if (claimed[sa[i]]) wc[i] = 1'b1;
          else begin claimed[sa[i]] = 1; win_d[sa[i]] = sd[i]; mm[sa[i]] = sd[i]; end
        end
      for (int i = 0; i < NP; i++)
        if (en[i]) begin
          if (we[i]) mrd[i] = sd[i];
`ifdef EXTBUS_WR_BYPASS_EN
          else if (claimed[sa[i]]) mrd[i] = win_d[sa[i]];
`endif
          else mrd[i] = old[sa[i]];
        end
      if (wc != 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    for (int i = 0; i < NP; i++) e.rd[i] = mrd[i];
    e.wc = wc; e.cnt = mcnt; e.cnt2 = mcnt2;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: every cycle is an output beat
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NP; i++) begin
          chk($sformatf("rdata%0d", i), rdata_a[i*W +: W], e.rd[i]);
          chk($sformatf("rdata%0d_cw2", i), rdata_b[i*W +: W], e.rd[i]);
        end
        chk("wr_conflict", W'(wc_a), W'(e.wc));
        chk("wr_conflict_cw2", W'(wc_b), W'(e.wc));
        chk("conflict_cnt", W'(cnt_a), W'(e.cnt));
        chk("conflict_cnt_cw2", W'(cnt_b), W'(e.cnt2));
      end
    end
  end

  task automatic set_port(input int p, input int a, input logic [W-1:0] d);
    sa[p] = a; sd[p] = d;
  endtask

  task automatic clr;
    for (int i = 0; i < NP; i++) begin sa[i] = 0; sd[i] = '0; end
  endtask

  initial begin
    clr();
    cyc(1, '0, '0);
    cyc(1, '0, '0);
    // 1: write then cross-port read
    clr(); set_port(0, 2, 72'h00_DEADBEEF_CAFEF00D);
    cyc(0, 4'b0001, 4'b0001);
    clr(); set_port(3, 2, '0);
    cyc(0, 4'b1000, 4'b0000);
    cyc(0, '0, '0);
    // 2: collision on addr 1, port2 loses
    clr(); set_port(1, 1, {9{8'h11}}); set_port(2, 1, {9{8'h22}});
    cyc(0, 4'b0110, 4'b0110);
    clr(); set_port(0, 1, '0);
    cyc(0, 4'b0001, 4'b0000);
    // 3: read addr 3 while another port writes it
    clr(); set_port(0, 3, 72'h5);
    cyc(0, 4'b0001, 4'b0001);
    clr(); set_port(0, 3, '0); set_port(1, 3, 72'h9);
    cyc(0, 4'b0011, 4'b0010);
    clr(); set_port(2, 3, '0);
    cyc(0, 4'b0100, 4'b0000);
    // 4: distinct writes, then crossed reads
    clr(); for (int i = 0; i < NP; i++) set_port(i, i, W'(i + 1));
    cyc(0, 4'b1111, 4'b1111);
    clr(); for (int i = 0; i < NP; i++) set_port(i, NP - 1 - i, '0);
    cyc(0, 4'b1111, 4'b0000);
    // 5: five collision cycles; narrow counter saturates
    for (int n = 0; n < 5; n++) begin
      clr(); set_port(0, 0, W'(n + 100)); set_port(1, 0, W'(n + 200));
      cyc(0, 4'b0011, 4'b0011);
    end
    // 6: fill with ones, reset during a write, read everything back
    clr(); for (int i = 0; i < NP; i++) set_port(i, i, '1);
    cyc(0, 4'b1111, 4'b1111);
    clr(); set_port(0, 1, 72'h1234);
    cyc(1, 4'b0001, 4'b0001);
    clr(); for (int i = 0; i < NP; i++) set_port(i, (i + 1) % NP, '0);
    cyc(0, 4'b1111, 4'b0000);
    clr(); set_port(0, 0, '0);
    cyc(0, 4'b0001, 4'b0000);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NP; i++)
        set_port(i, int'($urandom_range(0, DEPTH - 1)), {8'($urandom), $urandom, $urandom});
      cyc(($urandom_range(0, 59) == 0), 4'($urandom), 4'($urandom));
    end
    clr();
    cyc(0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
